// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO responder emulating a 32x16 PHY register file.
// MDC/MDIO are oversampled in the clock_50m domain.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int          PREAMBLE_MIN = 32,
    parameter logic [15:0] REG17_INIT   = 16'hAC00
) (
    input  logic        clock_50m,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    localparam int PCW = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PCW-1:0] PRE_MAX = PCW'(PREAMBLE_MIN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA,
        S_WRITE,
        S_SKIP
    } state_t;

    state_t          state;
    logic [2:0]      mdc_q;
    logic [1:0]      mdio_q;
    logic [PCW-1:0]  pre_cnt;
    logic [4:0]      bit_cnt;
    logic            op_b0;
    logic            op_rd;
    logic [3:0]      phy_sh;
    logic [4:0]      reg_addr;
    logic [15:0]     shreg;
    logic            ignore;
    logic            discard;
    logic [15:0]     regs [32];

    logic            mdc_rise;
    logic            mdc_fall;
    logic            bit_in;
    logic [4:0]      addr_nx;
    logic [15:0]     rd_word;

    function automatic logic [15:0] reg_init(input logic [4:0] a);
        logic [15:0] v;
        v = 16'h0000;
        case (a)
            5'd0:    v = 16'h1140;
            5'd1:    v = 16'h796D;
            5'd2:    v = 16'h0141;
            5'd3:    v = 16'h0CC2;
            5'd17:   v = REG17_INIT;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdc_fall = ~mdc_q[1] & mdc_q[2];
    assign bit_in   = mdio_q[1];
    assign addr_nx  = {reg_addr[3:0], bit_in};
    // reg0 bit15 (reset) always reads back as 0
    assign rd_word  = (addr_nx == 5'd0) ? {1'b0, regs[0][14:0]}
                                        : regs[addr_nx];

    // two-flop synchronisers plus a third mdc flop for edge detect
    always_ff @(posedge clock_50m) begin
        if (reset) begin
            mdc_q  <= 3'b000;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc};
            mdio_q <= {mdio_q[0], mdio_i};
        end
    end

    // register file, written one clock after the last data rise
    always_ff @(posedge clock_50m) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= reg_init(5'(i));
            end
        end else if (state == S_WRITE) begin
            case (reg_addr)
                5'd0:    regs[0] <= {1'b0, shreg[14:0]};
                5'd1,
                5'd2,
                5'd3:    ;
                default: regs[reg_addr] <= shreg;
            endcase
        end
    end

    // frame FSM: fields sampled on mdc rise, pad driven on mdc fall
    always_ff @(posedge clock_50m) begin
        if (reset) begin
            state     <= S_IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= 5'd0;
            op_b0     <= 1'b0;
            op_rd     <= 1'b0;
            phy_sh    <= 4'd0;
            reg_addr  <= 5'd0;
            shreg     <= 16'h0000;
            ignore    <= 1'b0;
            discard   <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 16'h0000;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mdc_rise) begin
                        if (bit_in) begin
                            if (pre_cnt < PRE_MAX) begin
                                pre_cnt <= pre_cnt + 1'b1;
                            end
                        end else if (pre_cnt >= PRE_MAX) begin
                            state <= S_ST;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                end
                S_ST: begin
                    if (mdc_rise) begin
                        bit_cnt <= 5'd0;
                        if (bit_in) begin
                            state <= S_OP;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                            pre_cnt   <= '0;
                        end
                    end
                end
                S_OP: begin
                    if (mdc_rise) begin
                        if (bit_cnt == 5'd0) begin
                            op_b0   <= bit_in;
                            bit_cnt <= 5'd1;
                        end else begin
                            bit_cnt <= 5'd0;
                            case ({op_b0, bit_in})
                                2'b10: begin
                                    op_rd <= 1'b1;
                                    state <= S_PHYAD;
                                end
                                2'b01: begin
                                    op_rd <= 1'b0;
                                    state <= S_PHYAD;
                                end
                                default: begin
                                    frame_err <= 1'b1;
                                    state     <= S_SKIP;
                                end
                            endcase
                        end
                    end
                end
                S_PHYAD: begin
                    if (mdc_rise) begin
                        phy_sh <= {phy_sh[2:0], bit_in};
                        if (bit_cnt == 5'd4) begin
                            ignore  <= ({phy_sh, bit_in} != PHY_ADDR);
                            bit_cnt <= 5'd0;
                            state   <= S_REGAD;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_REGAD: begin
                    if (mdc_rise) begin
                        reg_addr <= addr_nx;
                        if (bit_cnt == 5'd4) begin
                            shreg   <= rd_word;
                            discard <= 1'b0;
                            bit_cnt <= 5'd0;
                            state   <= S_TA;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_TA: begin
                    if (op_rd) begin
                        if (mdc_fall) begin
                            if (bit_cnt == 5'd0) begin
                                bit_cnt <= 5'd1;
                            end else begin
                                if (!ignore) begin
                                    mdio_oe <= 1'b1;
                                    mdio_o  <= 1'b0;
                                end
                                bit_cnt <= 5'd0;
                                state   <= S_DATA;
                            end
                        end
                    end else if (mdc_rise) begin
                        if (bit_cnt == 5'd0) begin
                            discard <= ~bit_in;
                            bit_cnt <= 5'd1;
                        end else begin
                            if (discard | bit_in) begin
                                discard   <= 1'b1;
                                frame_err <= ~ignore;
                            end
                            bit_cnt <= 5'd0;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (op_rd) begin
                        if (mdc_fall) begin
                            if (bit_cnt == 5'd16) begin
                                mdio_oe <= 1'b0;
                                mdio_o  <= 1'b1;
                                bit_cnt <= 5'd0;
                                pre_cnt <= '0;
                                state   <= S_IDLE;
                            end else begin
                                if (!ignore) begin
                                    mdio_o <= shreg[15];
                                end
                                shreg   <= {shreg[14:0], 1'b0};
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (mdc_rise) begin
                        shreg <= {shreg[14:0], bit_in};
                        if (bit_cnt == 5'd15) begin
                            bit_cnt <= 5'd0;
                            pre_cnt <= '0;
                            state   <= (ignore | discard) ? S_IDLE
                                                          : S_WRITE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_WRITE: begin
                    wr_strobe <= 1'b1;
                    wr_addr   <= reg_addr;
                    wr_data   <= shreg;
                    pre_cnt   <= '0;
                    state     <= S_IDLE;
                end
                S_SKIP: begin
                    if (mdc_rise) begin
                        if (bit_cnt == 5'd17) begin
                            bit_cnt <= 5'd0;
                            pre_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    pre_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder.
// MDC runs at clock_50m/10; a master model drives frames.
module tb_mdio_phy_responder;

    logic        clock_50m = 1'b0;
    logic        reset     = 1'b1;
    logic        mdc       = 1'b0;
    logic        mdio_m    = 1'b1;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int ferr_cnt = 0;
    int oe_cnt = 0;

    // open-drain style bus: responder wins while it drives
    assign mdio_i = mdio_oe ? mdio_o : mdio_m;

    always #10 clock_50m = ~clock_50m;

    mdio_phy_responder dut (
        .clock_50m (clock_50m),
        .reset     (reset),
        .mdc       (mdc),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    // event counters; tests compare deltas
    always @(posedge clock_50m) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (mdio_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock_50m);
    endtask

    task automatic mdc_bit(input logic b);
        mdc    = 1'b0;
        mdio_m = b;
        wait_n(5);
        mdc = 1'b1;
        wait_n(5);
    endtask

    // leading 0 breaks any ones left over from the previous frame
    task automatic send_header(input int pre, input logic [1:0] st,
                               input logic [1:0] op,
                               input logic [4:0] phy,
                               input logic [4:0] ra);
        mdc_bit(1'b0);
        for (int i = 0; i < pre; i++) mdc_bit(1'b1);
        for (int i = 1; i >= 0; i--) mdc_bit(st[i]);
        for (int i = 1; i >= 0; i--) mdc_bit(op[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(phy[i]);
        for (int i = 4; i >= 0; i--) mdc_bit(ra[i]);
    endtask

    task automatic read_frame(input int pre, input logic [4:0] phy,
                              input logic [4:0] ra, input bit drive,
                              input logic [15:0] exp, input int abort,
                              input string tag);
        logic [15:0] got;
        bit          oe_ok;
        int          oe0;
        oe0 = oe_cnt;
        send_header(pre, 2'b01, 2'b10, phy, ra);
        mdc    = 1'b0;
        mdio_m = 1'b1;
        wait_n(5);
        if (drive) check({tag, "_ta1_oe"}, 32'(mdio_oe), 32'd0);
        mdc = 1'b1;
        wait_n(5);
        mdc = 1'b0;
        wait_n(5);
        if (drive) check({tag, "_ta2"}, 32'({mdio_oe, mdio_o}), 32'd2);
        mdc = 1'b1;
        wait_n(5);
        got   = 16'h0000;
        oe_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mdc = 1'b0;
            wait_n(5);
            got = {got[14:0], mdio_i};
            if (!mdio_oe) oe_ok = 1'b0;
            if (i == abort) begin
                reset = 1'b1;
                @(posedge clock_50m);
                #1;
                check({tag, "_rst_oe"}, 32'(mdio_oe), 32'd0);
                @(negedge clock_50m);
                reset = 1'b0;
                wait_n(2);
                return;
            end
            mdc = 1'b1;
            wait_n(5);
        end
        mdc = 1'b0;
        wait_n(5);
        if (drive) check({tag, "_release"}, 32'(mdio_oe), 32'd0);
        mdc = 1'b1;
        wait_n(5);
        if (drive) begin
            check({tag, "_data"}, 32'(got), 32'(exp));
            check({tag, "_oe_held"}, 32'(oe_ok), 32'd1);
        end else begin
            check({tag, "_no_oe"}, 32'(oe_cnt - oe0), 32'd0);
        end
    endtask

    task automatic write_frame(input int pre, input logic [1:0] op,
                               input logic [4:0] phy,
                               input logic [4:0] ra,
                               input logic [1:0] ta,
                               input logic [15:0] d);
        send_header(pre, 2'b01, op, phy, ra);
        mdc_bit(ta[1]);
        mdc_bit(ta[0]);
        for (int i = 15; i >= 0; i--) mdc_bit(d[i]);
        mdc    = 1'b0;
        mdio_m = 1'b1;
        wait_n(5);
    endtask

    initial begin
        int s0;
        int f0;
        int o0;

        wait_n(3);
        check("rst_oe", 32'(mdio_oe), 32'd0);
        check("rst_o", 32'(mdio_o), 32'd1);
        check("rst_outs", {10'd0, wr_strobe, wr_addr, wr_data, frame_err},
              32'd0);
        reset = 1'b0;
        wait_n(2);

        read_frame(32, 5'd1, 5'd2, 1'b1, 16'h0141, -1, "rd_r2");
        read_frame(32, 5'd1, 5'd17, 1'b1, 16'hAC00, -1, "rd_r17");

        s0 = strobe_cnt;
        o0 = oe_cnt;
        write_frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h01E1);
        check("wr4_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("wr4_addr", 32'(wr_addr), 32'd4);
        check("wr4_data", 32'(wr_data), 32'h01E1);
        check("wr4_no_oe", 32'(oe_cnt - o0), 32'd0);
        read_frame(32, 5'd1, 5'd4, 1'b1, 16'h01E1, -1, "rd_r4");

        read_frame(32, 5'd5, 5'd2, 1'b0, 16'h0000, -1, "rd_phy5");
        read_frame(32, 5'd1, 5'd2, 1'b1, 16'h0141, -1, "rd_after_phy5");

        read_frame(31, 5'd1, 5'd0, 1'b0, 16'h0000, -1, "rd_pre31");
        s0 = strobe_cnt;
        write_frame(31, 2'b01, 5'd1, 5'd5, 2'b10, 16'h1234);
        check("wr_pre31_strobe", 32'(strobe_cnt - s0), 32'd0);
        read_frame(32, 5'd1, 5'd5, 1'b1, 16'h0000, -1, "rd_r5");
        read_frame(32, 5'd1, 5'd0, 1'b1, 16'h1140, -1, "rd_r0");

        s0 = strobe_cnt;
        write_frame(32, 2'b01, 5'd1, 5'd0, 2'b10, 16'h9140);
        check("wr0_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("wr0_data", 32'(wr_data), 32'h9140);
        read_frame(32, 5'd1, 5'd0, 1'b1, 16'h1140, -1, "rd_r0_sc");

        s0 = strobe_cnt;
        write_frame(32, 2'b01, 5'd1, 5'd1, 2'b10, 16'h0000);
        check("wr1_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("wr1_addr", 32'(wr_addr), 32'd1);
        read_frame(32, 5'd1, 5'd1, 1'b1, 16'h796D, -1, "rd_r1_ro");

        f0 = ferr_cnt;
        send_header(32, 2'b00, 2'b10, 5'd1, 5'd2);
        mdc_bit(1'b1);
        mdc_bit(1'b1);
        check("bad_st_err", 32'(ferr_cnt - f0), 32'd1);

        f0 = ferr_cnt;
        s0 = strobe_cnt;
        write_frame(32, 2'b11, 5'd1, 5'd6, 2'b10, 16'hFFFF);
        check("bad_op_err", 32'(ferr_cnt - f0), 32'd1);
        check("bad_op_strobe", 32'(strobe_cnt - s0), 32'd0);

        f0 = ferr_cnt;
        s0 = strobe_cnt;
        write_frame(32, 2'b01, 5'd1, 5'd6, 2'b11, 16'h5555);
        check("bad_ta_err", 32'(ferr_cnt - f0), 32'd1);
        check("bad_ta_strobe", 32'(strobe_cnt - s0), 32'd0);
        read_frame(32, 5'd1, 5'd6, 1'b1, 16'h0000, -1, "rd_r6");

        read_frame(32, 5'd1, 5'd4, 1'b1, 16'h01E1, 8, "rd_abort");
        read_frame(32, 5'd1, 5'd4, 1'b1, 16'h0000, -1, "rd_r4_rst");
        read_frame(32, 5'd1, 5'd17, 1'b1, 16'hAC00, -1, "rd_r17_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
